// File: rtl/bip_pkg.sv
// Shared definitions for the BIP run/debug sequencer: state encoding and opcode defaults.
package bip_pkg;

  localparam int NB_OPCODE_DEF = 5;
  localparam logic [NB_OPCODE_DEF-1:0] HALT_OPCODE_DEF = 5'h00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_STEP     = 3'd2,
    ST_HALT     = 3'd3,
    ST_DUMP_RD  = 3'd4,
    ST_DUMP_CAP = 3'd5,
    ST_DUMP_OUT = 3'd6
  } state_e;

  function automatic logic is_dump_state(input state_e s);
    return (s == ST_DUMP_RD) || (s == ST_DUMP_CAP) || (s == ST_DUMP_OUT);
  endfunction

endpackage

// File: rtl/bip_cycle_counter.sv
// Saturating counter of enabled cycles; holds at all-ones and clears only on reset.
module bip_cycle_counter #(
  parameter int NB_CYCLE = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  output logic [NB_CYCLE-1:0] o_cnt
);

  logic [NB_CYCLE-1:0] cnt_q;
  logic [NB_CYCLE-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en && (cnt_q != {NB_CYCLE{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/bip_run_ctrl.sv
// BIP execution/debug sequencer: run, single-step, halt on HLT, and data-RAM dump to a host.
// Optional cycle counter enabled by defining BIP_CYCLE_COUNTER_EN.
module bip_run_ctrl
  import bip_pkg::*;
#(
  parameter int                   NB_OPCODE   = NB_OPCODE_DEF,
  parameter int                   NB_DATA     = 16,
  parameter int                   NB_RAM_ADDR = 11,
  parameter int                   NB_CYCLE    = 32,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = NB_OPCODE'(HALT_OPCODE_DEF)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NB_OPCODE-1:0]   i_opcode,
  input  logic                   i_run,
  input  logic                   i_step,
  input  logic                   i_dump,
  input  logic [NB_DATA-1:0]     i_ram_rdata,
  input  logic                   i_dump_ready,
  output logic                   o_cpu_en,
  output logic                   o_ram_sel,
  output logic                   o_dump_rd,
  output logic [NB_RAM_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0]     o_dump_data,
  output logic                   o_dump_valid,
  output logic                   o_dump_last,
  output logic                   o_halted,
  output logic [NB_CYCLE-1:0]    o_cycle_cnt
);

  localparam logic [NB_RAM_ADDR-1:0] ADDR_LAST = {NB_RAM_ADDR{1'b1}};

  state_e                 state_q, state_d;
  logic                   ret_halt_q, ret_halt_d;
  logic [NB_RAM_ADDR-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0]     data_q, data_d;
  logic                   ram_sel_q, ram_sel_d;
  logic                   dump_rd_q, dump_rd_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic                   is_hlt;

  assign is_hlt = (i_opcode == HALT_OPCODE);

  // Next-state logic; status outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    state_d    = state_q;
    ret_halt_d = ret_halt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d = ST_RUN;
        end else if (i_step) begin
          state_d = ST_STEP;
        end else if (i_dump) begin
          state_d    = ST_DUMP_RD;
          ret_halt_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (is_hlt) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        state_d = is_hlt ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        if (i_dump) begin
          state_d    = ST_DUMP_RD;
          ret_halt_d = 1'b1;
        end
      end
      ST_DUMP_RD: begin
        state_d = ST_DUMP_CAP;
      end
      ST_DUMP_CAP: begin
        data_d  = i_ram_rdata;
        state_d = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: begin
        if (i_dump_ready) begin
          if (addr_q == ADDR_LAST) begin
            addr_d  = '0;
            state_d = ret_halt_q ? ST_HALT : ST_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_DUMP_RD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ram_sel_d = is_dump_state(state_d);
    dump_rd_d = (state_d == ST_DUMP_RD);
    valid_d   = (state_d == ST_DUMP_OUT);
    halted_d  = (state_d == ST_HALT) || (is_dump_state(state_d) && ret_halt_d);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      ret_halt_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ram_sel_q  <= 1'b0;
      dump_rd_q  <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_halt_q <= ret_halt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ram_sel_q  <= ram_sel_d;
      dump_rd_q  <= dump_rd_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  // Combinational so the CPU is frozen in the very cycle the HLT opcode appears.
  assign o_cpu_en     = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !is_hlt;
  assign o_ram_sel    = ram_sel_q;
  assign o_dump_rd    = dump_rd_q;
  assign o_dump_addr  = addr_q;
  assign o_dump_data  = data_q;
  assign o_dump_valid = valid_q;
  assign o_dump_last  = valid_q && (addr_q == ADDR_LAST);
  assign o_halted     = halted_q;

`ifdef BIP_CYCLE_COUNTER_EN
  bip_cycle_counter #(
    .NB_CYCLE(NB_CYCLE)
  ) u_cycle_counter (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (o_cpu_en),
    .o_cnt (o_cycle_cnt)
  );
`else
  assign o_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_bip_run_ctrl.sv
// Self-checking bench for bip_run_ctrl with a behavioural RAM and expected-value model.
module tb_bip_run_ctrl;

  localparam int NB_OPCODE   = 5;
  localparam int NB_DATA     = 16;
  localparam int NB_RAM_ADDR = 3;
  localparam int NB_CYCLE    = 32;
  localparam int NWORDS      = 1 << NB_RAM_ADDR;
`ifdef BIP_CYCLE_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   resetN;
  logic [NB_OPCODE-1:0]   opcodeIn;
  logic                   runIn, stepIn, dumpIn, readyIn;
  logic [NB_DATA-1:0]     ramRdata;
  logic                   cpuEn, ramSel, dumpRd, dumpValid, dumpLast, halted;
  logic [NB_RAM_ADDR-1:0] dumpAddr;
  logic [NB_DATA-1:0]     dumpData;
  logic [NB_CYCLE-1:0]    cycleCnt;

  logic [NB_DATA-1:0] mem [NWORDS];
  int total = 0;
  int bad = 0;
  int cntExp = 0;

  bip_run_ctrl #(
    .NB_OPCODE(NB_OPCODE), .NB_DATA(NB_DATA), .NB_RAM_ADDR(NB_RAM_ADDR),
    .NB_CYCLE(NB_CYCLE), .HALT_OPCODE(5'h00)
  ) dut (
    .i_clk(clock), .i_rst(resetN), .i_opcode(opcodeIn), .i_run(runIn),
    .i_step(stepIn), .i_dump(dumpIn), .i_ram_rdata(ramRdata), .i_dump_ready(readyIn),
    .o_cpu_en(cpuEn), .o_ram_sel(ramSel), .o_dump_rd(dumpRd), .o_dump_addr(dumpAddr),
    .o_dump_data(dumpData), .o_dump_valid(dumpValid), .o_dump_last(dumpLast),
    .o_halted(halted), .o_cycle_cnt(cycleCnt)
  );

  always #5 clock = ~clock;

  // Synchronous-read data RAM: word appears the cycle after the read strobe.
  always @(posedge clock) begin
    if (dumpRd) ramRdata <= mem[dumpAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic run, input logic step, input logic dump,
                               input logic [NB_OPCODE-1:0] op);
    runIn    = run;
    stepIn   = step;
    dumpIn   = dump;
    opcodeIn = op;
    #1;
  endtask

  task automatic checkCpu(input string tag, input logic expEn);
    checkOutput({tag, "_cpu_en"}, 32'(cpuEn), 32'(expEn));
    checkOutput({tag, "_cnt"}, cycleCnt, 32'(cntExp));
    if (CNT_ON && expEn) cntExp++;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    readyIn = 1'b0;
    applyStimulus(0, 0, 0, 5'd1);
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    cntExp = 0;
    #1;
    checkOutput("rst_ram_sel", 32'(ramSel), 0);
    checkOutput("rst_valid", 32'(dumpValid), 0);
    checkOutput("rst_halted", 32'(halted), 0);
    checkOutput("rst_addr", 32'(dumpAddr), 0);
    checkOutput("rst_data", 32'(dumpData), 0);
    checkCpu("rst", 1'b0);
  endtask

  // Runs a program: len non-HLT opcodes followed by HLT, ending in HALT.
  task automatic runToHalt(input int len, input bit rnd);
    logic [NB_OPCODE-1:0] op;
    applyStimulus(1, 0, 0, 5'd2);
    checkCpu("run_idle", 1'b0);
    tick();
    for (int i = 0; i < len; i++) begin
      op = rnd ? NB_OPCODE'($urandom_range(1, 31)) : ((i == 0) ? 5'd2 : (i == 1) ? 5'd3 : 5'd1);
      applyStimulus(0, 0, 0, op);
      checkCpu("run", 1'b1);
      tick();
    end
    applyStimulus(0, 0, 0, 5'd0);
    checkCpu("run_hlt", 1'b0);
    checkOutput("run_hlt_halted", 32'(halted), 0);
    tick();
    applyStimulus(0, 0, 0, NB_OPCODE'($urandom_range(1, 31)));
    checkOutput("halt_halted", 32'(halted), 1);
    checkCpu("halt", 1'b0);
  endtask

  // Streams the full RAM out and compares each accepted word with the model RAM.
  task automatic runDump(input bit expHalted, input bit randReady, input int stallWord, input int stallLen);
    int word = 0;
    int stall = 0;
    bit done = 0;
    applyStimulus(0, 0, 1, 5'd7);
    tick();
    applyStimulus(0, 0, 0, 5'd7);
    for (int c = 0; c < 400 && !done; c++) begin
      if (randReady) readyIn = 1'($urandom_range(0, 1));
      else readyIn = !(word == stallWord && stall < stallLen);
      dumpIn = 1'($urandom_range(0, 1));
      #1;
      checkOutput("dump_ram_sel", 32'(ramSel), 1);
      checkOutput("dump_halted", 32'(halted), 32'(expHalted));
      checkOutput("dump_cpu_en", 32'(cpuEn), 0);
      if (dumpValid) begin
        checkOutput("dump_addr", 32'(dumpAddr), 32'(word));
        checkOutput("dump_data", 32'(dumpData), 32'(mem[word]));
        checkOutput("dump_last", 32'(dumpLast), 32'(word == NWORDS - 1));
        if (readyIn) begin
          word++;
          stall = 0;
          if (word == NWORDS) done = 1;
        end else begin
          stall++;
        end
      end else begin
        checkOutput("dump_last_idle", 32'(dumpLast), 0);
      end
      tick();
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL dump_timeout observed=%0d words expected=%0d", word, NWORDS);
    end
    readyIn = 1'b0;
    applyStimulus(0, 0, 0, 5'd7);
    checkOutput("post_dump_ram_sel", 32'(ramSel), 0);
    checkOutput("post_dump_valid", 32'(dumpValid), 0);
    checkOutput("post_dump_halted", 32'(halted), 32'(expHalted));
    checkOutput("post_dump_addr", 32'(dumpAddr), 0);
  endtask

  initial begin
    bit found;
    ramRdata = '0;
    for (int k = 0; k < NWORDS; k++) mem[k] = 16'h100 + 16'(k);

    $display("[TB] run to HLT");
    doReset();
    runToHalt(3, 0);
    checkOutput("run_total_cnt", cycleCnt, CNT_ON ? 32'd3 : 32'd0);

    $display("[TB] single step");
    doReset();
    for (int p = 0; p < 3; p++) begin
      applyStimulus(0, 1, 0, 5'd1);
      checkCpu("step_idle", 1'b0);
      tick();
      applyStimulus(0, 0, 0, 5'd1);
      checkCpu("step_pulse", 1'b1);
      for (int w = 0; w < 3; w++) begin
        tick();
        checkCpu("step_after", 1'b0);
        checkOutput("step_halted", 32'(halted), 0);
      end
    end

    $display("[TB] dump with backpressure from HALT");
    doReset();
    runToHalt(3, 0);
    runDump(1, 0, 2, 5);
    applyStimulus(1, 1, 0, 5'd3);
    checkCpu("halt_after_dump", 1'b0);
    tick();
    applyStimulus(0, 0, 0, 5'd3);
    checkCpu("halt_after_dump_run", 1'b0);

    $display("[TB] priority and ignore");
    doReset();
    applyStimulus(1, 1, 0, 5'd5);
    tick();
    applyStimulus(0, 0, 0, 5'd5);
    checkCpu("prio_run", 1'b1);
    tick();
    applyStimulus(0, 0, 1, 5'd5);
    checkCpu("prio_still_run", 1'b1);
    tick();
    applyStimulus(0, 0, 0, 5'd6);
    checkOutput("run_dump_ignored", 32'(ramSel), 0);
    checkCpu("run_dump_cpu", 1'b1);
    tick();
    applyStimulus(0, 0, 0, 5'd0);
    checkCpu("prio_hlt", 1'b0);
    tick();
    applyStimulus(1, 1, 0, 5'd4);
    checkOutput("halt_reached", 32'(halted), 1);
    tick();
    applyStimulus(0, 0, 0, 5'd4);
    checkCpu("halt_run_ignored", 1'b0);
    checkOutput("halt_stays", 32'(halted), 1);

    $display("[TB] reset mid-dump");
    applyStimulus(0, 0, 1, 5'd4);
    tick();
    applyStimulus(0, 0, 0, 5'd4);
    readyIn = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (dumpValid && dumpAddr == 3'd4) found = 1;
      else tick();
    end
    checkOutput("mid_dump_reached", 32'(found), 1);
    readyIn = 1'b0;
    resetN = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(dumpValid), 0);
    checkOutput("abort_ram_sel", 32'(ramSel), 0);
    checkOutput("abort_halted", 32'(halted), 0);
    checkOutput("abort_addr", 32'(dumpAddr), 0);
    tick();
    resetN = 1'b1;
    cntExp = 0;
    tick();
    checkOutput("release_addr", 32'(dumpAddr), 0);
    checkOutput("release_halted", 32'(halted), 0);
    applyStimulus(0, 1, 0, 5'd1);
    checkCpu("release_idle", 1'b0);
    tick();
    applyStimulus(0, 0, 0, 5'd1);
    checkCpu("release_step", 1'b1);

    $display("[TB] randomized programs and dumps");
    for (int r = 0; r < 4; r++) begin
      doReset();
      for (int k = 0; k < NWORDS; k++) mem[k] = 16'($urandom);
      runDump(0, 1, -1, 0);
      applyStimulus(0, 1, 0, 5'd9);
      tick();
      applyStimulus(0, 0, 0, 5'd9);
      checkCpu("rand_idle_step", 1'b1);
      tick();
      runToHalt($urandom_range(1, 12), 1);
      for (int k = 0; k < NWORDS; k++) mem[k] = 16'($urandom);
      runDump(1, 1, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
